// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the ALU front-end controller:
//   - state_t : FSM states; the encoding is also the value shown on the phase LEDs.
//   - opcode constants for the 4-bit ALU and OPCODE_MAX, the last valid opcode.
//   - opcode_invalid() : true for opcodes the ALU does not implement.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] MUL  = 4'd2;
  localparam logic [3:0] NAND = 4'd3;
  localparam logic [3:0] AND  = 4'd4;
  localparam logic [3:0] OR   = 4'd5;
  localparam logic [3:0] XOR  = 4'd6;
  localparam logic [3:0] XNOR = 4'd7;

  localparam logic [3:0] OPCODE_MAX = XNOR;

  function automatic logic opcode_invalid(input logic [3:0] op);
    return (op > OPCODE_MAX);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Synchronises and debounces one raw push button and emits a one-cycle
//   pulse for every accepted press (0->1 change of the debounced level).
//   Ports:
//     clk        in  system clock
//     clr_common in  synchronous active-high reset
//     raw        in  asynchronous, bouncing button level
//     press      out one-cycle pulse, registered, on each accepted press
//   A level change is accepted after DEBOUNCE_CYCLES consecutive cycles in
//   which the synchronised input differs from the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic clr_common,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          press_reg;
  logic [CW-1:0] count_reg;

  logic differ;
  logic flip;

  assign differ = (sync2_reg != stable_reg);
  // The cycle that would bring the count to DEBOUNCE_CYCLES flips the level
  // directly, so the counter never has to hold the terminal value.
  assign flip   = differ && (count_reg == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (clr_common) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      press_reg  <= 1'b0;
      count_reg  <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (!differ || flip) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
      if (flip) begin
        stable_reg <= ~stable_reg;
      end
      // Only the rising flip is a press; the release is silent.
      press_reg <= flip && sync2_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/alu_entry_sequencer.sv
// alu_entry_sequencer
//   Single-button entry path for the 4-bit ALU: walks the user through
//   operand A, operand B and opcode, strobes each into the ALU registers,
//   waits out the ALU latency and latches the 8-bit result for display.
//   Ports:
//     clk          in   system clock
//     clr_common   in   synchronous active-high reset (shared with ALU regs)
//     btn_enter    in   raw enter button
//     btn_cancel   in   raw cancel button
//     data[3:0]    in   slide switches
//     alu_result   in   ALU output O[7:0]
//     ld_a/ld_b/ld_op out one-cycle load strobes
//     ld_data[3:0] out  value to load, valid while any ld_* is high
//     result[7:0]  out  latched ALU result
//     result_valid out  result belongs to the last completed entry
//     err          out  last captured opcode was out of range
//     phase[2:0]   out  current state for the LEDs
module alu_entry_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESULT_WAIT     = 2
) (
  input  logic       clk,
  input  logic       clr_common,
  input  logic       btn_enter,
  input  logic       btn_cancel,
  input  logic [3:0] data,
  input  logic [7:0] alu_result,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_op,
  output logic [3:0] ld_data,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       err,
  output logic [2:0] phase
);

  localparam int WW = (RESULT_WAIT < 1) ? 1 : $clog2(RESULT_WAIT + 1);

  // Index 0 = enter, index 1 = cancel.
  logic [1:0] raw_btns;
  logic [1:0] presses;
  logic       enter_press;
  logic       cancel_press;

  assign raw_btns     = {btn_cancel, btn_enter};
  assign enter_press  = presses[0];
  assign cancel_press = presses[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk        (clk),
        .clr_common (clr_common),
        .raw        (raw_btns[gi]),
        .press      (presses[gi])
      );
    end
  endgenerate

  state_t        state_reg,   state_next;
  logic [WW-1:0] wait_reg,    wait_next;
  logic          ld_a_reg,    ld_a_next;
  logic          ld_b_reg,    ld_b_next;
  logic          ld_op_reg,   ld_op_next;
  logic [3:0]    ld_data_reg, ld_data_next;
  logic [7:0]    result_reg,  result_next;
  logic          valid_reg,   valid_next;
  logic          err_reg,     err_next;

  always_ff @(posedge clk) begin
    if (clr_common) begin
      state_reg   <= GET_A;
      wait_reg    <= '0;
      ld_a_reg    <= 1'b0;
      ld_b_reg    <= 1'b0;
      ld_op_reg   <= 1'b0;
      ld_data_reg <= 4'd0;
      result_reg  <= 8'h00;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      ld_a_reg    <= ld_a_next;
      ld_b_reg    <= ld_b_next;
      ld_op_reg   <= ld_op_next;
      ld_data_reg <= ld_data_next;
      result_reg  <= result_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    ld_a_next    = 1'b0;
    ld_b_next    = 1'b0;
    ld_op_next   = 1'b0;
    ld_data_next = ld_data_reg;
    result_next  = result_reg;
    valid_next   = valid_reg;
    err_next     = err_reg;

    // Cancel overrides everything, including a same-cycle enter and a
    // capture that would otherwise happen this cycle.
    if (cancel_press) begin
      state_next = GET_A;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        GET_A: begin
          if (enter_press) begin
            ld_a_next    = 1'b1;
            ld_data_next = data;
            state_next   = GET_B;
          end
        end
        GET_B: begin
          if (enter_press) begin
            ld_b_next    = 1'b1;
            ld_data_next = data;
            state_next   = GET_OP;
          end
        end
        GET_OP: begin
          if (enter_press) begin
            ld_op_next   = 1'b1;
            ld_data_next = data;
            err_next     = opcode_invalid(data);
            wait_next    = WW'(RESULT_WAIT);
            state_next   = EXEC;
          end
        end
        EXEC: begin
          // Enter presses here are simply ignored.
          if (wait_reg == '0) begin
            result_next = alu_result;
            valid_next  = 1'b1;
            state_next  = SHOW;
          end else begin
            wait_next = wait_reg - 1'b1;
          end
        end
        SHOW: begin
          if (enter_press) begin
            valid_next = 1'b0;
            state_next = GET_A;
          end
        end
        default: begin
          state_next = GET_A;
        end
      endcase
    end
  end

  assign ld_a         = ld_a_reg;
  assign ld_b         = ld_b_reg;
  assign ld_op        = ld_op_reg;
  assign ld_data      = ld_data_reg;
  assign result       = result_reg;
  assign result_valid = valid_reg;
  assign err          = err_reg;
  assign phase        = state_reg;

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// tb_alu_entry_sequencer
//   Directed bench for alu_entry_sequencer with DEBOUNCE_CYCLES=4 and a
//   behavioural ALU (A/B/op registers plus an output register, 2-cycle
//   latency). Expected results are hand-computed constants.
module tb_alu_entry_sequencer;
  import alu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       clr_common;
  logic       btn_enter;
  logic       btn_cancel;
  logic [3:0] data;
  logic [7:0] alu_result;
  logic       ld_a, ld_b, ld_op;
  logic [3:0] ld_data;
  logic [7:0] result;
  logic       result_valid;
  logic       err;
  logic [2:0] phase;

  always #5 clk = ~clk;

  alu_entry_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .RESULT_WAIT    (2)
  ) dut (
    .clk          (clk),
    .clr_common   (clr_common),
    .btn_enter    (btn_enter),
    .btn_cancel   (btn_cancel),
    .data         (data),
    .alu_result   (alu_result),
    .ld_a         (ld_a),
    .ld_b         (ld_b),
    .ld_op        (ld_op),
    .ld_data      (ld_data),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .phase        (phase)
  );

  // ---------------- ALU model ----------------
  logic [3:0] alu_a, alu_b, alu_op;

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return {4'h0, a} + {4'h0, b};
      4'd1:    return {4'h0, a} - {4'h0, b};
      4'd2:    return {4'h0, a} * {4'h0, b};
      4'd3:    return {4'h0, ~(a & b)};
      4'd4:    return {4'h0, a & b};
      4'd5:    return {4'h0, a | b};
      4'd6:    return {4'h0, a ^ b};
      4'd7:    return {4'h0, ~(a ^ b)};
      default: return 8'hFF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (clr_common) begin
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_op     <= 4'd0;
      alu_result <= 8'h00;
    end else begin
      if (ld_a)  alu_a  <= ld_data;
      if (ld_b)  alu_b  <= ld_data;
      if (ld_op) alu_op <= ld_data;
      alu_result <= alu_f(alu_a, alu_b, alu_op);
    end
  end

  // ---------------- strobe monitor ----------------
  int         cnt_ld_a = 0, cnt_ld_b = 0, cnt_ld_op = 0;
  logic [3:0] last_a = 4'd0, last_b = 4'd0, last_op = 4'd0;

  always @(negedge clk) begin
    if (ld_a)  begin cnt_ld_a++;  last_a  = ld_data; end
    if (ld_b)  begin cnt_ld_b++;  last_b  = ld_data; end
    if (ld_op) begin cnt_ld_op++; last_op = ld_data; end
  end

  // ---------------- helpers ----------------
  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic e, input logic c);
    btn_enter  = e;
    btn_cancel = c;
    repeat (6) tick();
    btn_enter  = 1'b0;
    btn_cancel = 1'b0;
    repeat (8) tick();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30 && !result_valid; i++) tick();
  endtask

  task automatic do_entry(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    data = a;  press(1'b1, 1'b0);
    data = b;  press(1'b1, 1'b0);
    data = op; press(1'b1, 1'b0);
    wait_valid();
    $display("entry A=%0h B=%0h op=%0h -> result=%02h valid=%0b err=%0b phase=%0d",
             a, b, op, result, result_valid, err, phase);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int a0, b0, op0;

  initial begin
    clr_common = 1'b1;
    btn_enter  = 1'b0;
    btn_cancel = 1'b0;
    data       = 4'd0;
    repeat (3) tick();

    // Reset state
    check("rst_phase", phase, 0);
    check("rst_ld", {ld_a, ld_b, ld_op}, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_result", result, 8'h00);
    check("rst_valid", result_valid, 0);
    check("rst_err", err, 0);
    clr_common = 1'b0;
    repeat (2) tick();

    // 3 + 5 ADD
    do_entry(4'd3, 4'd5, ADD);
    check("add_cnt_a", cnt_ld_a, 1);
    check("add_cnt_b", cnt_ld_b, 1);
    check("add_cnt_op", cnt_ld_op, 1);
    check("add_data_a", last_a, 3);
    check("add_data_b", last_b, 5);
    check("add_data_op", last_op, 0);
    check("add_result", result, 8'h08);
    check("add_valid", result_valid, 1);
    check("add_err", err, 0);
    check("add_phase", phase, 4);

    // F * F
    press(1'b1, 1'b0);
    check("ack1_phase", phase, 0);
    check("ack1_valid", result_valid, 0);
    check("ack1_result_held", result, 8'h08);
    do_entry(4'hF, 4'hF, MUL);
    check("mul_result", result, 8'hE1);
    check("mul_valid", result_valid, 1);

    // 2 - 5
    press(1'b1, 1'b0);
    do_entry(4'd2, 4'd5, SUB);
    check("sub_result", result, 8'hFD);
    check("sub_valid", result_valid, 1);

    // Glitch rejection then a clean press
    press(1'b1, 1'b0);
    check("ack3_phase", phase, 0);
    a0 = cnt_ld_a;
    btn_enter = 1'b1;
    repeat (3) tick();
    btn_enter = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      btn_enter = ~btn_enter;
      tick();
    end
    btn_enter = 1'b0;
    repeat (8) tick();
    $display("glitch: ld_a count delta=%0d phase=%0d", cnt_ld_a - a0, phase);
    check("glitch_no_ld_a", cnt_ld_a - a0, 0);
    check("glitch_phase", phase, 0);
    data = 4'd1;
    press(1'b1, 1'b0);
    $display("clean press: ld_a count delta=%0d phase=%0d", cnt_ld_a - a0, phase);
    check("clean_one_ld_a", cnt_ld_a - a0, 1);
    check("clean_phase", phase, 1);
    press(1'b0, 1'b1);
    check("cancel_phase", phase, 0);

    // Invalid opcode
    do_entry(4'hA, 4'h3, 4'd9);
    check("inv_result", result, 8'hFF);
    check("inv_err", err, 1);
    press(1'b1, 1'b0);
    check("inv_err_held", err, 1);
    check("inv_result_held", result, 8'hFF);
    do_entry(4'd6, 4'd3, AND);
    check("and_result", result, 8'h02);
    check("and_err", err, 0);

    // Enter and cancel together in GET_OP
    press(1'b1, 1'b0);
    data = 4'd1; press(1'b1, 1'b0);
    data = 4'd2; press(1'b1, 1'b0);
    check("both_pre_phase", phase, 2);
    op0 = cnt_ld_op;
    data = 4'd0;
    press(1'b1, 1'b1);
    $display("enter+cancel: phase=%0d ld_op delta=%0d valid=%0b result=%02h",
             phase, cnt_ld_op - op0, result_valid, result);
    check("both_phase", phase, 0);
    check("both_no_ld_op", cnt_ld_op - op0, 0);
    check("both_valid", result_valid, 0);
    check("both_result_held", result, 8'h02);

    // Reset during EXEC
    data = 4'd7; press(1'b1, 1'b0);
    data = 4'd7; press(1'b1, 1'b0);
    data = ADD;
    btn_enter = 1'b1;
    repeat (6) tick();
    btn_enter = 1'b0;
    tick();
    check("exec_phase", phase, 3);
    check("exec_ld_op", ld_op, 1);
    clr_common = 1'b1;
    tick();
    clr_common = 1'b0;
    $display("reset in EXEC: phase=%0d result=%02h valid=%0b err=%0b", phase, result, result_valid, err);
    check("mid_rst_phase", phase, 0);
    check("mid_rst_ld", {ld_a, ld_b, ld_op}, 0);
    check("mid_rst_ld_data", ld_data, 0);
    check("mid_rst_result", result, 8'h00);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_err", err, 0);
    b0 = cnt_ld_b;
    repeat (10) tick();
    check("post_rst_no_capture", result_valid, 0);
    check("post_rst_phase", phase, 0);
    check("post_rst_result", result, 8'h00);
    do_entry(4'd1, 4'd1, ADD);
    check("final_result", result, 8'h02);
    check("final_valid", result_valid, 1);
    check("final_ld_b", cnt_ld_b - b0, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/alu_entry_sequencer.md
# alu_entry_sequencer

Front-end controller for the 4-bit ALU on the Spartan-3E board. It takes one raw "enter" button, one raw "cancel" button and the 4 data switches, and steps the user through operand A, operand B and opcode. It drives one-cycle load strobes into the ALU's three operand/opcode registers, waits out the ALU latency, then latches and holds the 8-bit result for display. It replaces the three separate load buttons with a single debounced, sequenced entry path.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized cycles needed to accept a button level change (board build overrides to ~500000).
- RESULT_WAIT, 2: cycles from load-strobe to ALU output valid (1 register stage + 1 ALU output register).
- clk  in  1  system clock; single clock domain.
- clr_common  in  1  synchronous, active-high reset; shared with the ALU registers.
- btn_enter  in  1  raw, asynchronous, bouncing push button.
- btn_cancel  in  1  raw, asynchronous, bouncing push button.
- data  in  4  slide switches (quasi-static).
- alu_result  in  8  ALU output O.
- ld_a / ld_b / ld_op  out  1 each  one-cycle load strobes to the A, B and opcode registers.
- ld_data  out  4  registered copy of data; valid while any ld_* is high.
- result  out  8  latched ALU result.
- result_valid  out  1  result corresponds to the last completed entry.
- err  out  1  last captured opcode > 7.
- phase  out  3  state encoding for the LEDs.

## Operation
- Both buttons pass through btn_debounce: 2-flop synchronizer; counter increments while sync != stable level and clears otherwise; stable flips when count reaches DEBOUNCE_CYCLES; a one-cycle press pulse fires on each 0->1 flip of stable.
- FSM states, phase encoding: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SHOW=4.
- GET_A, enter press: ld_a pulse, ld_data=data; go to GET_B.
- GET_B, enter press: ld_b pulse; go to GET_OP.
- GET_OP, enter press: ld_op pulse; err <= (data > 7); load wait counter with RESULT_WAIT; go to EXEC.
- EXEC: counter decrements each cycle. At zero: result <= alu_result, result_valid <= 1; go to SHOW. Enter presses in EXEC are dropped, not queued.
- SHOW, enter press: result_valid <= 0; go to GET_A. result and err hold until the next capture.
- Cancel press in any state: go to GET_A. No strobe is issued, result_valid <= 0, result and err are held.
- Enter and cancel pressing in the same cycle: cancel wins.
- Width rule: result is copied verbatim from the 8-bit ALU output. Invalid opcodes (8–15) yield 0xFF with err=1.

## Timing
- Reset values: phase=0 (GET_A), ld_a=ld_b=ld_op=0, ld_data=0, result=0x00, result_valid=0, err=0, debouncer stable levels=0, counters=0.
- A raw edge at cycle t that is stable thereafter gives a press pulse in cycle t+2+DEBOUNCE_CYCLES. Pulses shorter than DEBOUNCE_CYCLES produce no press.
- ld_* and ld_data are registered: high exactly one cycle, in the cycle after the press pulse. The state updates in the same cycle as the strobe.
- If ld_op is high in cycle s, result_valid rises in cycle s+RESULT_WAIT+1, and result is stable from that cycle.
- Reset mid-operation (any state, including EXEC): all outputs return to reset values on the next edge. Any pending capture is abandoned. A press already in progress must be re-debounced.

## Structure
- Package alu_ctrl_pkg holds:
  - phase/state encodings GET_A..SHOW;
  - opcode constants ADD=0, SUB=1, MUL=2, NAND=3, AND=4, OR=5, XOR=6, XNOR=7;
  - OPCODE_MAX=7.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, clr_common, raw, press) is instantiated twice.
- The FSM, wait counter and output registers live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and an ALU model with 2-cycle latency.
- Enter A=3, B=5, op=0 -> ld_a/ld_b/ld_op each high one cycle with ld_data 3, 5, 0; result=0x08, result_valid=1, err=0, phase=4.
- A=0xF, B=0xF, op=2 -> result=0xE1. Then A=2, B=5, op=1 -> result=0xFD.
- Enter glitch 3 cycles wide, then bouncing 1-cycle toggles -> no strobe, phase stays 0. A clean 6-cycle press -> exactly one ld_a.
- op=9 -> err=1, result=0xFF. Next entry with op=4 -> err=0.
- In GET_OP, enter and cancel pressed in the same cycle -> phase=0, no ld_op, result_valid=0, previous result held.
- clr_common asserted for one cycle during EXEC -> all outputs reach reset values the next cycle, no capture occurs. A following full entry A=1, B=1, op=0 -> result=0x02.
